// File: rtl/multdiv_ctrl.sv
// Sequencing FSM for the iterative Booth multiplier / non-restoring divider.
// Register-control outputs are registered from the next state; alu_op and exception are combinational.
module multdiv_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             ctrl_mult,
   input  logic             ctrl_div,
   input  logic [1:0]       booth_bits,
   input  logic             rem_sign,
   input  logic             divisor_zero,
   input  logic             mult_ovf,
   output logic             reg_en,
   output logic             reg_clr,
   output logic             reg_out_en,
   output logic             init_sel,
   output logic [1:0]       alu_op,
   output logic             shift_en,
   output logic             is_div,
   output logic [CNT_W-1:0] iter_cnt,
   output logic             busy,
   output logic             result_rdy,
   output logic             exception
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ITER,
      FIX,
      DONE
   } state_t;

   localparam logic [1:0] ALU_NOP = 2'b00;
   localparam logic [1:0] ALU_ADD = 2'b01;
   localparam logic [1:0] ALU_SUB = 2'b10;

   state_t           state;
   state_t           next_state;
   logic             dz_flag;
   logic             next_dz;
   logic             next_is_div;
   logic [CNT_W-1:0] next_cnt;
   logic             last_iter;

   assign last_iter = (iter_cnt == CNT_W'(WIDTH - 1));

   // The latched divide-by-zero flag only reaches the pipeline while DONE is presented
   assign exception = (state == DONE) & (dz_flag | (~is_div & mult_ovf));

   always_comb begin
      next_state  = state;
      next_is_div = is_div;
      next_dz     = dz_flag;
      next_cnt    = '0;
      alu_op      = ALU_NOP;
      case (state)
         IDLE: begin
            next_dz = 1'b0;
            if (ctrl_mult) begin
               next_state  = LOAD;
               next_is_div = 1'b0;
            end else if (ctrl_div) begin
               next_state  = LOAD;
               next_is_div = 1'b1;
            end
         end
         LOAD: begin
            if (is_div && divisor_zero) begin
               next_state = DONE;
               next_dz    = 1'b1;
            end else begin
               next_state = ITER;
            end
         end
         ITER: begin
            if (last_iter) begin
               next_state = is_div ? FIX : DONE;
            end else begin
               next_cnt = iter_cnt + CNT_W'(1);
            end
            if (is_div) begin
               alu_op = rem_sign ? ALU_ADD : ALU_SUB;
            end else begin
               case (booth_bits)
                  2'b01:   alu_op = ALU_ADD;
                  2'b10:   alu_op = ALU_SUB;
                  default: alu_op = ALU_NOP;
               endcase
            end
         end
         FIX: begin
            next_state = DONE;
            alu_op     = rem_sign ? ALU_ADD : ALU_NOP;
         end
         DONE: begin
            next_state  = IDLE;
            next_is_div = 1'b0;
            next_dz     = 1'b0;
         end
         default: begin
            next_state  = IDLE;
            next_is_div = 1'b0;
            next_dz     = 1'b0;
         end
      endcase
   end

   // Outputs are decoded from next_state so they are glitch-free flops aligned with the state
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state      <= IDLE;
         is_div     <= 1'b0;
         dz_flag    <= 1'b0;
         iter_cnt   <= '0;
         reg_en     <= 1'b0;
         reg_clr    <= 1'b1;
         reg_out_en <= 1'b0;
         init_sel   <= 1'b0;
         shift_en   <= 1'b0;
         busy       <= 1'b0;
         result_rdy <= 1'b0;
      end else begin
         state      <= next_state;
         is_div     <= next_is_div;
         dz_flag    <= next_dz;
         iter_cnt   <= next_cnt;
         reg_en     <= (next_state == LOAD) || (next_state == ITER) || (next_state == FIX);
         reg_clr    <= 1'b0;
         reg_out_en <= (next_state == DONE);
         init_sel   <= (next_state == LOAD);
         shift_en   <= (next_state == ITER);
         busy       <= (next_state != IDLE);
         result_rdy <= (next_state == DONE);
      end
   end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed scenarios plus randomized operations,
// each cycle compared against a cycle-index model of the operation timeline.
module tb_multdiv_ctrl;

   localparam int W  = 32;
   localparam int CW = 6;
   localparam logic [16:0] IDLE_VEC = 17'h00000;
   localparam logic [16:0] RST_VEC  = 17'h04000;

   logic          clk = 1'b0;
   logic          clr_n;
   logic          ctrl_mult;
   logic          ctrl_div;
   logic [1:0]    booth_bits;
   logic          rem_sign;
   logic          divisor_zero;
   logic          mult_ovf;
   logic          reg_en;
   logic          reg_clr;
   logic          reg_out_en;
   logic          init_sel;
   logic [1:0]    alu_op;
   logic          shift_en;
   logic          is_div;
   logic [CW-1:0] iter_cnt;
   logic          busy;
   logic          result_rdy;
   logic          exception;

   int checks = 0;
   int errors = 0;

   multdiv_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk          (clk),
      .clr_n        (clr_n),
      .ctrl_mult    (ctrl_mult),
      .ctrl_div     (ctrl_div),
      .booth_bits   (booth_bits),
      .rem_sign     (rem_sign),
      .divisor_zero (divisor_zero),
      .mult_ovf     (mult_ovf),
      .reg_en       (reg_en),
      .reg_clr      (reg_clr),
      .reg_out_en   (reg_out_en),
      .init_sel     (init_sel),
      .alu_op       (alu_op),
      .shift_en     (shift_en),
      .is_div       (is_div),
      .iter_cnt     (iter_cnt),
      .busy         (busy),
      .result_rdy   (result_rdy),
      .exception    (exception)
   );

   always #5 clk = ~clk;

   // Vector layout: busy reg_en reg_clr reg_out_en init_sel shift_en result_rdy exception alu_op[2] is_div iter_cnt[6]
   function automatic logic [16:0] observed();
      return {busy, reg_en, reg_clr, reg_out_en, init_sel, shift_en, result_rdy,
              exception, alu_op, is_div, iter_cnt};
   endfunction

   // kind: 0 multiply, 1 divide, 2 divide-by-zero; k = cycles since the start edge (0 = before it)
   function automatic logic [16:0] model(int kind, int k, logic [1:0] bb, logic rs, logic ovf);
      int            lat;
      logic          b, ld, it, fx, dn, ex, dv;
      logic [1:0]    a;
      logic [CW-1:0] c;
      lat = (kind == 0) ? W + 2 : (kind == 1) ? W + 3 : 2;
      b   = (k >= 1) && (k <= lat);
      ld  = (k == 1);
      it  = (kind != 2) && (k >= 2) && (k <= W + 1);
      fx  = (kind == 1) && (k == W + 2);
      dn  = (k == lat);
      ex  = dn && ((kind == 2) || ((kind == 0) && ovf));
      dv  = b && (kind != 0);
      a   = 2'b00;
      if (it && kind == 1)      a = rs ? 2'b01 : 2'b10;
      else if (it)              a = (bb == 2'b01) ? 2'b01 : (bb == 2'b10) ? 2'b10 : 2'b00;
      else if (fx)              a = rs ? 2'b01 : 2'b00;
      c = it ? CW'(k - 2) : '0;
      return {b, ld | it | fx, 1'b0, dn, ld, it, dn, ex, a, dv, c};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clr_n = 1'b0; ctrl_mult = 1'b0; ctrl_div = 1'b0; booth_bits = 2'b00;
      rem_sign = 1'b0; divisor_zero = 1'b0; mult_ovf = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (observed() !== RST_VEC) begin
            errors++;
            $display("[TB] FAIL reset_hold%0d got %h exp %h", i, observed(), RST_VEC);
         end
      end
      clr_n = 1'b1;
      step();
      checks++;
      if (observed() !== IDLE_VEC) begin
         errors++;
         $display("[TB] FAIL reset_release got %h exp %h", observed(), IDLE_VEC);
      end
   endtask

   task automatic test_mult_sub();
      int rdy_cnt = 0;
      for (int k = 0; k <= W + 3; k++) begin
         ctrl_mult = (k == 0); ctrl_div = 1'b0; booth_bits = 2'b10;
         rem_sign = 1'b0; divisor_zero = 1'b0; mult_ovf = 1'b0;
         @(negedge clk);
         rdy_cnt += int'(result_rdy);
         checks++;
         if (observed() !== model(0, k, 2'b10, 1'b0, 1'b0)) begin
            errors++;
            $display("[TB] FAIL mult_sub k=%0d got %h exp %h", k, observed(), model(0, k, 2'b10, 1'b0, 1'b0));
         end
         step();
      end
      checks++;
      if (rdy_cnt !== 1) begin
         errors++;
         $display("[TB] FAIL mult_sub_rdy_count got %0d exp 1", rdy_cnt);
      end
   endtask

   task automatic test_div_by_zero();
      for (int k = 0; k <= 4; k++) begin
         ctrl_mult = 1'b0; ctrl_div = (k == 0); booth_bits = 2'($urandom);
         rem_sign = 1'($urandom); divisor_zero = 1'b1; mult_ovf = 1'($urandom);
         @(negedge clk);
         checks++;
         if (observed() !== model(2, k, booth_bits, rem_sign, mult_ovf)) begin
            errors++;
            $display("[TB] FAIL div_zero k=%0d got %h exp %h", k, observed(), model(2, k, booth_bits, rem_sign, mult_ovf));
         end
         step();
      end
      divisor_zero = 1'b0;
   endtask

   task automatic test_div_restore();
      for (int k = 0; k <= W + 4; k++) begin
         ctrl_mult = 1'b0; ctrl_div = (k == 0); booth_bits = 2'($urandom);
         rem_sign = 1'b1; divisor_zero = 1'b0; mult_ovf = 1'($urandom);
         @(negedge clk);
         checks++;
         if (observed() !== model(1, k, booth_bits, 1'b1, mult_ovf)) begin
            errors++;
            $display("[TB] FAIL div_restore k=%0d got %h exp %h", k, observed(), model(1, k, booth_bits, 1'b1, mult_ovf));
         end
         step();
      end
   endtask

   task automatic test_dual_start();
      for (int k = 0; k <= W + 3; k++) begin
         ctrl_mult = (k == 0); ctrl_div = (k == 0) || (k == 10); booth_bits = 2'($urandom);
         rem_sign = 1'($urandom); divisor_zero = 1'($urandom); mult_ovf = 1'b0;
         @(negedge clk);
         checks++;
         if (observed() !== model(0, k, booth_bits, rem_sign, 1'b0)) begin
            errors++;
            $display("[TB] FAIL dual_start k=%0d got %h exp %h", k, observed(), model(0, k, booth_bits, rem_sign, 1'b0));
         end
         step();
      end
      ctrl_div = 1'b0; divisor_zero = 1'b0;
   endtask

   task automatic test_abort();
      int rdy_cnt = 0;
      for (int k = 0; k <= 15; k++) begin
         ctrl_mult = (k == 0); ctrl_div = 1'b0; booth_bits = 2'($urandom);
         rem_sign = 1'b0; divisor_zero = 1'b0; mult_ovf = 1'b0;
         clr_n = (k != 15);
         @(negedge clk);
         checks++;
         if (observed() !== model(0, k, booth_bits, 1'b0, 1'b0)) begin
            errors++;
            $display("[TB] FAIL abort_pre k=%0d got %h exp %h", k, observed(), model(0, k, booth_bits, 1'b0, 1'b0));
         end
         step();
      end
      clr_n = 1'b1;
      checks++;
      if (observed() !== RST_VEC) begin
         errors++;
         $display("[TB] FAIL abort_reset got %h exp %h", observed(), RST_VEC);
      end
      step();
      for (int i = 0; i < W; i++) begin
         rdy_cnt += int'(result_rdy | busy | reg_out_en);
         step();
      end
      checks++;
      if (rdy_cnt !== 0) begin
         errors++;
         $display("[TB] FAIL abort_quiet active_cycles got %0d exp 0", rdy_cnt);
      end
      for (int k = 0; k <= W + 3; k++) begin
         ctrl_mult = (k == 0); booth_bits = 2'($urandom); mult_ovf = 1'($urandom);
         @(negedge clk);
         checks++;
         if (observed() !== model(0, k, booth_bits, 1'b0, mult_ovf)) begin
            errors++;
            $display("[TB] FAIL abort_restart k=%0d got %h exp %h", k, observed(), model(0, k, booth_bits, 1'b0, mult_ovf));
         end
         step();
      end
   endtask

   task automatic test_mult_overflow();
      int oe_cnt = 0;
      for (int k = 0; k <= W + 3; k++) begin
         ctrl_mult = (k == 0); ctrl_div = 1'b0; booth_bits = 2'($urandom);
         rem_sign = 1'($urandom); divisor_zero = 1'b0; mult_ovf = 1'b1;
         @(negedge clk);
         oe_cnt += int'(reg_out_en);
         checks++;
         if (observed() !== model(0, k, booth_bits, rem_sign, 1'b1)) begin
            errors++;
            $display("[TB] FAIL mult_ovf k=%0d got %h exp %h", k, observed(), model(0, k, booth_bits, rem_sign, 1'b1));
         end
         step();
      end
      mult_ovf = 1'b0;
      checks++;
      if (oe_cnt !== 1) begin
         errors++;
         $display("[TB] FAIL mult_ovf_out_en_cycles got %0d exp 1", oe_cnt);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 24; n++) begin
         int kind = int'($urandom_range(0, 2));
         int lat  = (kind == 0) ? W + 2 : (kind == 1) ? W + 3 : 2;
         for (int k = 0; k <= lat + 1; k++) begin
            booth_bits = 2'($urandom); rem_sign = 1'($urandom); mult_ovf = 1'($urandom);
            if (k == 0) begin
               ctrl_mult = (kind == 0);
               ctrl_div  = (kind != 0) ? 1'b1 : 1'($urandom);
            end else if (k >= 2 && k <= lat) begin
               ctrl_mult = 1'($urandom);
               ctrl_div  = 1'($urandom);
            end else begin
               ctrl_mult = 1'b0;
               ctrl_div  = 1'b0;
            end
            divisor_zero = (k == 1) ? (kind == 2) : 1'($urandom);
            @(negedge clk);
            checks++;
            if (observed() !== model(kind, k, booth_bits, rem_sign, mult_ovf)) begin
               errors++;
               $display("[TB] FAIL random op=%0d kind=%0d k=%0d got %h exp %h", n, kind, k,
                        observed(), model(kind, k, booth_bits, rem_sign, mult_ovf));
            end
            step();
         end
      end
      ctrl_mult = 1'b0; ctrl_div = 1'b0; divisor_zero = 1'b0;
   endtask

   initial begin
      test_reset();
      test_mult_sub();
      test_div_by_zero();
      test_div_restore();
      test_dual_start();
      test_abort();
      test_mult_overflow();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
